fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction buffer between the fetch and decode stages. Decouples fetch
//  from decode stalls so fetch keeps issuing while decode is blocked.
//  Upstream: fetch produces {pc, inst} with a Valid/Allow_in handshake.
//  Downstream: decode consumes entries in FIFO order using the same handshake.
//  A branch/redirect flush discards every buffered entry in one cycle.
// PARAMETERS
//  DATA_W  64  entry width; {pc[31:0], inst[31:0]} by default
//  DEPTH   4   number of entries; power of two, >= 2
//  CNT_W   $clog2(DEPTH)+1  occupancy counter width (derived; do not override)
// PORTS
//  clk           in   1       clock; all state updates on the rising edge
//  resetn        in   1       synchronous, active-low reset
//  flush         in   1       discard all entries (branch taken / redirect)
//  in_valid      in   1       upstream entry valid
//  in_data       in   DATA_W  upstream entry
//  in_allow_in   out  1       queue accepts an entry this cycle
//  out_valid     out  1       head entry valid
//  out_data      out  DATA_W  head entry
//  out_allow_in  in   1       downstream consumes the head this cycle
//  count         out  CNT_W   current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (resetn==0 at a clk edge): rd_ptr=wr_ptr=0, count=0.
//    Resulting outputs: out_valid=0, in_allow_in=1, out_data=don't-care.
//  - in_allow_in = (count != DEPTH) && !flush. No combinational path from out_allow_in.
//  - push = in_valid && in_allow_in. Writes mem[wr_ptr] and increments wr_ptr.
//  - out_valid = (count != 0) && !flush. out_data = mem[rd_ptr], read combinationally.
//  - pop = out_valid && out_allow_in. Increments rd_ptr.
//  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//  - count update per cycle:
//    * push only: +1
//    * pop only: -1
//    * push and pop together: unchanged. This is legal when 0 < count < DEPTH.
//  - Full (count==DEPTH): push is refused even if a pop occurs the same cycle.
//    Upstream retries on the next cycle.
//  - Empty (count==0): out_valid=0. Latency from push to out_valid is 1 cycle.
//  - flush has priority over push and pop.
//    * Next state: rd_ptr=wr_ptr=0, count=0.
//    * in_valid is ignored in the flush cycle.
//  - Reset mid-operation behaves like flush and also wins over it. All contents are lost.
//  - Upstream holds in_data stable while in_valid && !in_allow_in.
//    The queue does not check this.
// CONFIGURATION
//  FETCH_QUEUE_BYPASS_EN
//   - Defined: when count==0, in_valid, out_allow_in and !flush are all true, in_data is
//     forwarded to out_data with out_valid=1 in the same cycle, and nothing is stored.
//     Push-to-consume latency is 0 in that case.
//     in_allow_in is additionally 1 whenever this bypass condition holds.
//   - Undefined: there is no bypass, minimum latency is 1 cycle, and there is no
//     combinational in->out path.
// STRUCTURE
//  - Shared package cpu_pipe_pkg:
//    * IF_ID_BUS_W=64
//    * localparams for the pc/inst field offsets inside the entry
//    * the default FETCH_QUEUE_DEPTH
//  - One sub-module: fetch_queue_mem. DEPTH x DATA_W register array with one write port
//    and one asynchronous read port. No reset on the data array.
//  - Pointer, counter and handshake logic live in fetch_queue itself.
// TESTING
//  - Reset: hold resetn=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0 and
//    in_allow_in=1 after release.
//  - Fill: out_allow_in=0, push 0xA0..0xA3 on 4 cycles -> count=4, in_allow_in=0.
//    A 5th push with data 0xA4 is refused.
//  - Drain/order: continuing the fill test, set out_allow_in=1 -> out_data reads
//    A0,A1,A2,A3 on consecutive cycles, then out_valid=0 and count=0.
//  - Simultaneous push and pop at count=2 for 10 cycles -> count stays 2, the FIFO order
//    is preserved, and the pointers wrap at least twice.
//  - Flush: count=3 with flush=1 and in_valid=1 on the same cycle -> the next cycle has
//    count=0 and out_valid=0, and the flushing-cycle entry is not stored.
//  - Bypass: with the macro, when empty and out_allow_in=1, push 0x55 -> out_data=0x55 and
//    out_valid=1 in the same cycle, and count stays 0. Without the macro, 0x55 appears
//    one cycle later.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared fetch/decode pipeline definitions: IF->ID bus width, entry field
// offsets and the default fetch queue depth.
package cpu_pipe_pkg;

    localparam int unsigned IF_ID_BUS_W       = 64;
    localparam int unsigned IF_ID_PC_W        = 32;
    localparam int unsigned IF_ID_INST_W      = 32;
    localparam int unsigned IF_ID_INST_LSB    = 0;
    localparam int unsigned IF_ID_INST_MSB    = IF_ID_INST_LSB + IF_ID_INST_W - 1;
    localparam int unsigned IF_ID_PC_LSB      = IF_ID_INST_MSB + 1;
    localparam int unsigned IF_ID_PC_MSB      = IF_ID_PC_LSB + IF_ID_PC_W - 1;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    // One fetched instruction as it travels from fetch to decode.
    typedef struct packed {
        logic [IF_ID_PC_W-1:0]   pc;
        logic [IF_ID_INST_W-1:0] inst;
    } if_id_entry_t;

    // Build a flat IF->ID bus word from its fields.
    function automatic logic [IF_ID_BUS_W-1:0] pack_if_id(
        input logic [IF_ID_PC_W-1:0]   pc,
        input logic [IF_ID_INST_W-1:0] inst
    );
        if_id_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        return IF_ID_BUS_W'(e);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch->queue->decode handshake bundle. The queue takes the slave side;
// the fetch/decode pair (or a bench) takes the master side.
interface fetch_queue_if #(
    parameter int unsigned DATA_W = cpu_pipe_pkg::IF_ID_BUS_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_allow_in;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_allow_in;

    modport master (
        output in_valid,
        output in_data,
        output out_allow_in,
        input  in_allow_in,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_allow_in,
        output in_allow_in,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage: DEPTH x DATA_W register array, one write port,
// one asynchronous read port. Contents are not reset.
module fetch_queue_mem #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the addressed entry on push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Head entry is visible in the same cycle its address is presented.
    always_comb begin
        rd_data = mem_q[rd_addr];
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode. FIFO of {pc, inst} entries
// with Valid/Allow_in handshakes on both sides and a one-cycle flush.
// Optional feature: FETCH_QUEUE_BYPASS_EN forwards in_data straight to
// out_data when the queue is empty and decode is ready.
module fetch_queue
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = IF_ID_BUS_W,
    parameter int unsigned DEPTH  = FETCH_QUEUE_DEPTH,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    fetch_queue_if.slave      bus,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    logic              full_c;
    logic              empty_c;
    logic              bypass_c;
    logic              push_c;
    logic              pop_c;
    logic              allow_c;
    logic              valid_c;
    logic [DATA_W-1:0] rd_data;

    // Occupancy decode from the registered counter.
    always_comb begin
        full_c  = (count_q == CNT_W'(DEPTH));
        empty_c = (count_q == '0);
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with a ready consumer: hand the entry straight through.
    always_comb begin
        bypass_c = empty_c && bus.in_valid && bus.out_allow_in && !flush;
    end
`else
    // No forwarding path; every entry is stored before it is seen.
    always_comb begin
        bypass_c = 1'b0;
    end
`endif

    // Handshake outputs and the resulting push/pop strobes.
    always_comb begin
        allow_c = (!full_c && !flush) || bypass_c;
        valid_c = (!empty_c && !flush) || bypass_c;
        push_c  = bus.in_valid && allow_c && !bypass_c;
        pop_c   = valid_c && bus.out_allow_in && !bypass_c;
    end

    assign bus.in_allow_in = allow_c;
    assign bus.out_valid   = valid_c;
    assign bus.out_data    = bypass_c ? bus.in_data : rd_data;
    assign count           = count_q;

    // Next pointer and occupancy; flush discards everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_c),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run, all compared against a queue-based reference model.
module tb_fetch_queue;
    import cpu_pipe_pkg::*;

    localparam int unsigned DATA_W = IF_ID_BUS_W;
    localparam int unsigned DEPTH  = FETCH_QUEUE_DEPTH;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic             clk;
    logic             resetn;
    logic             flush;
    logic [CNT_W-1:0] count;

    fetch_queue_if #(.DATA_W(DATA_W)) fq ();

    fetch_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (fq.slave),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: contents as a plain queue, outputs from the rules.
    logic [DATA_W-1:0] mq [$];
    bit                exp_allow;
    bit                exp_valid;
    bit                exp_byp;
    logic [DATA_W-1:0] exp_data;

    function automatic void model_eval();
        exp_byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        exp_byp = (mq.size() == 0) && fq.in_valid && fq.out_allow_in && !flush;
`endif
        exp_allow = (!flush && mq.size() < DEPTH) || exp_byp;
        exp_valid = (!flush && mq.size() > 0) || exp_byp;
        exp_data  = exp_byp ? fq.in_data : ((mq.size() > 0) ? mq[0] : '0);
    endfunction

    function automatic void model_commit();
        if (!resetn || flush) begin
            mq.delete();
        end else if (!exp_byp) begin
            if (exp_valid && fq.out_allow_in) void'(mq.pop_front());
            if (fq.in_valid && exp_allow) mq.push_back(fq.in_data);
        end
    endfunction

    task automatic set_in(input bit iv, input logic [DATA_W-1:0] d, input bit oa, input bit fl);
        fq.in_valid     = iv;
        fq.in_data      = d;
        fq.out_allow_in = oa;
        flush           = fl;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return pack_if_id($urandom, $urandom);
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        set_in(1'b1, rnd_data(), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            settle();
            advance();
        end
        resetn = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0);
        settle();
        n_tests++;
        if (count !== CNT_W'(0)) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", count);
        end
        n_tests++;
        if (fq.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", fq.out_valid);
        end
        n_tests++;
        if (fq.in_allow_in !== 1'b1) begin
            n_fail++; $display("FAIL reset_allow: got %b want 1", fq.in_allow_in);
        end
        advance();
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = DATA_W'(32'hA0 + i);
            set_in(1'b1, d, 1'b0, 1'b0);
            settle();
            n_tests++;
            if (fq.in_allow_in !== 1'b1 || count !== CNT_W'(i)) begin
                n_fail++;
                $display("FAIL fill_push%0d: allow=%b count=%0d want allow=1 count=%0d", i, fq.in_allow_in, count, i);
            end
            advance();
        end
        d = DATA_W'(32'hA4);
        set_in(1'b1, d, 1'b0, 1'b0);
        settle();
        n_tests++;
        if (count !== CNT_W'(4) || fq.in_allow_in !== 1'b0 || exp_allow) begin
            n_fail++;
            $display("FAIL fill_full: count=%0d allow=%b want count=4 allow=0", count, fq.in_allow_in);
        end
        advance();
    endtask

    task automatic test_drain();
        logic [DATA_W-1:0] want;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            settle();
            want = DATA_W'(32'hA0 + i);
            n_tests++;
            if (fq.out_valid !== 1'b1 || fq.out_data !== want || exp_data !== want) begin
                n_fail++;
                $display("FAIL drain_order%0d: valid=%b data=%h want valid=1 data=%h", i, fq.out_valid, fq.out_data, want);
            end
            advance();
        end
        settle();
        n_tests++;
        if (fq.out_valid !== 1'b0 || count !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%b count=%0d want valid=0 count=0", fq.out_valid, count);
        end
        advance();
    endtask

    task automatic test_push_pop();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, rnd_data(), 1'b0, 1'b0);
            settle();
            advance();
        end
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, rnd_data(), 1'b1, 1'b0);
            settle();
            n_tests++;
            if (count !== CNT_W'(2) || fq.in_allow_in !== 1'b1 || fq.out_valid !== 1'b1 ||
                fq.out_data !== exp_data) begin
                n_fail++;
                $display("FAIL push_pop%0d: count=%0d allow=%b valid=%b data=%h want count=2 allow=1 valid=1 data=%h",
                         i, count, fq.in_allow_in, fq.out_valid, fq.out_data, exp_data);
            end
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            settle();
            n_tests++;
            if (fq.out_valid !== 1'b1 || fq.out_data !== exp_data) begin
                n_fail++;
                $display("FAIL push_pop_tail%0d: valid=%b data=%h want valid=1 data=%h", i, fq.out_valid, fq.out_data, exp_data);
            end
            advance();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, rnd_data(), 1'b0, 1'b0);
            settle();
            advance();
        end
        set_in(1'b1, DATA_W'(32'hEE), 1'b1, 1'b1);
        settle();
        n_tests++;
        if (count !== CNT_W'(3) || fq.in_allow_in !== 1'b0 || fq.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: count=%0d allow=%b valid=%b want count=3 allow=0 valid=0", count, fq.in_allow_in, fq.out_valid);
        end
        advance();
        set_in(1'b0, '0, 1'b0, 1'b0);
        settle();
        n_tests++;
        if (count !== CNT_W'(0) || fq.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: count=%0d valid=%b want count=0 valid=0", count, fq.out_valid);
        end
        advance();
        set_in(1'b1, DATA_W'(32'h77), 1'b0, 1'b0);
        settle();
        advance();
        set_in(1'b0, '0, 1'b1, 1'b0);
        settle();
        n_tests++;
        if (count !== CNT_W'(1) || fq.out_data !== DATA_W'(32'h77)) begin
            n_fail++;
            $display("FAIL flush_refill: count=%0d data=%h want count=1 data=77", count, fq.out_data);
        end
        advance();
    endtask

    task automatic test_bypass();
        set_in(1'b1, DATA_W'(32'h55), 1'b1, 1'b0);
        settle();
`ifdef FETCH_QUEUE_BYPASS_EN
        n_tests++;
        if (fq.out_valid !== 1'b1 || fq.out_data !== DATA_W'(32'h55) || fq.in_allow_in !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_same: valid=%b data=%h allow=%b want valid=1 data=55 allow=1", fq.out_valid, fq.out_data, fq.in_allow_in);
        end
        advance();
        set_in(1'b0, '0, 1'b1, 1'b0);
        settle();
        n_tests++;
        if (count !== CNT_W'(0) || fq.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_nostore: count=%0d valid=%b want count=0 valid=0", count, fq.out_valid);
        end
        advance();
`else
        n_tests++;
        if (fq.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nobypass_same: valid=%b want 0", fq.out_valid);
        end
        advance();
        set_in(1'b0, '0, 1'b1, 1'b0);
        settle();
        n_tests++;
        if (fq.out_valid !== 1'b1 || fq.out_data !== DATA_W'(32'h55) || count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL nobypass_next: valid=%b data=%h count=%0d want valid=1 data=55 count=1", fq.out_valid, fq.out_data, count);
        end
        advance();
        settle();
        n_tests++;
        if (count !== CNT_W'(0)) begin
            n_fail++;
            $display("FAIL nobypass_drain: count=%0d want 0", count);
        end
        advance();
`endif
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            resetn = ($urandom_range(0, 63) != 0);
            set_in(($urandom_range(0, 3) != 0), rnd_data(),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            settle();
            n_tests++;
            if (fq.in_allow_in !== exp_allow || fq.out_valid !== exp_valid ||
                count !== CNT_W'(mq.size()) || (exp_valid && fq.out_data !== exp_data)) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random%0d: allow=%b valid=%b count=%0d data=%h want allow=%b valid=%b count=%0d data=%h",
                             i, fq.in_allow_in, fq.out_valid, count, fq.out_data,
                             exp_allow, exp_valid, mq.size(), exp_data);
            end
            advance();
        end
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        test_reset();
        test_fill();
        test_drain();
        test_push_pop();
        test_flush();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
